mac_tx_packet_arbiter: RTL and testbench

- Shares the single 64-bit 10G MAC TX AXI-Stream input between NUM_PORTS packet sources, for example ARP, ICMP, TCP and UDP engines.
- Arbitration is packet-granular round-robin. Once a port is granted, it keeps the grant until its tlast beat is accepted.
- Sits in the clk156 domain, directly in front of the network module TX stream.
- New grants are issued only while the link reports reset-done.

---
 rtl/mac_tx_packet_arbiter_pkg.sv | 28 ++
 rtl/mac_tx_packet_arbiter_if.sv | 47 ++++
 rtl/mac_tx_packet_arbiter_rr_pick.sv | 49 ++++
 rtl/mac_tx_packet_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mac_tx_packet_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_tx_packet_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_arb_pkg
// Purpose  : Shared types and defaults for the MAC TX packet arbiter.
//            Provides the arbiter state encoding, default stream widths and
//            a helper for sizing port-index fields.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mac_tx_arb_pkg;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_KEEP_WIDTH = 8;
  localparam int PKT_CNT_W      = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Width of an index able to address n ports; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_tx_packet_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_packet_arbiter_if
// Purpose  : Bundles the NUM_PORTS source AXI-Stream inputs and the single
//            MAC-side AXI-Stream output of the TX packet arbiter.
// Ports    : s_axis_* - packed per-port source streams (port i at slice i)
//            m_axis_* - merged stream toward the MAC TX
// Modports : master - the sources and MAC (drive s_axis_*, m_axis_tready)
//            slave  - the arbiter (drives s_axis_tready, m_axis_*)
// Revision : 1.0 - initial release
// ============================================================================
interface mac_tx_packet_arbiter_if
  import mac_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DEF_KEEP_WIDTH
) ();

  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [NUM_PORTS-1:0]            s_axis_tready;

  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [KEEP_WIDTH-1:0]           m_axis_tkeep;
  logic                            m_axis_tvalid;
  logic                            m_axis_tlast;
  logic                            m_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

endinterface
`default_nettype wire

// File: rtl/mac_tx_packet_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Picks the first requesting
//            port searching upward from (last_i + 1) with wrap-around.
// Ports    : req_i  - request vector, one bit per port
//            last_i - index of the most recently served port
//            sel_o  - one-hot selection (all zero when no request)
//            idx_o  - binary index of the selection (0 when no request)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import mac_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_i,
  output logic [NUM_PORTS-1:0] sel_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic found;

  // Two passes replace a modulo search: ports above last_i win first, and
  // only if none of them request do ports at or below last_i get a look.
  always_comb begin
    sel_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_i[i] && (i > int'(last_i))) begin
        found    = 1'b1;
        sel_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_i[i] && (i <= int'(last_i))) begin
        found    = 1'b1;
        sel_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_packet_arbiter
// Purpose  : Packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream
//            sources onto the single 10G MAC TX stream (clk156 domain).
//            A granted port keeps the grant until its tlast beat is accepted;
//            new grants are issued only while link_ready is high.
// Ports    : clk156     - 156.25 MHz network clock
//            aresetn    - synchronous active-low reset
//            link_ready - network reset done, gates new grants only
//            bus        - source / MAC streams (slave modport)
//            grant      - one-hot current grant, 0 when idle
//            pkt_count  - packets forwarded (accepted tlast beats), wraps
// Revision : 1.0 - initial release
// ============================================================================
module mac_tx_packet_arbiter
  import mac_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DEF_KEEP_WIDTH
) (
  input  logic                  clk156,
  input  logic                  aresetn,
  input  logic                  link_ready,
  mac_tx_packet_arbiter_if.slave bus,
  output logic [NUM_PORTS-1:0]  grant,
  output logic [PKT_CNT_W-1:0]  pkt_count
);

  localparam int               IDX_W    = idx_w(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_PORTS - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [PKT_CNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]  tkeep_q, tkeep_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;

  logic [NUM_PORTS-1:0]   pick_sel;
  logic [IDX_W-1:0]       pick_idx;
  logic [DATA_WIDTH-1:0]  mux_data;
  logic [KEEP_WIDTH-1:0]  mux_keep;
  logic                   mux_last;
  logic                   out_free;
  logic [NUM_PORTS-1:0]   s_ready;
  logic                   accept;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req_i  (bus.s_axis_tvalid),
    .last_i (last_q),
    .sel_o  (pick_sel),
    .idx_o  (pick_idx)
  );

  // One-hot AND-OR mux of the granted port's beat.
  always_comb begin
    mux_data = '0;
    mux_keep = '0;
    mux_last = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        mux_data = mux_data | bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        mux_keep = mux_keep | bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        mux_last = mux_last | bus.s_axis_tlast[i];
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign out_free = !tvalid_q || bus.m_axis_tready;
  assign s_ready  = ((state_q == XFER) && out_free) ? grant_q : '0;
  assign accept   = |(s_ready & bus.s_axis_tvalid);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    last_d      = last_q;
    pkt_count_d = pkt_count_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;

    // A new beat takes priority over draining, keeping tvalid high.
    if (accept) begin
      tdata_d  = mux_data;
      tkeep_d  = mux_keep;
      tlast_d  = mux_last;
      tvalid_d = 1'b1;
    end else if (bus.m_axis_tready) begin
      tdata_d  = '0;
      tkeep_d  = '0;
      tlast_d  = 1'b0;
      tvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (link_ready && (|bus.s_axis_tvalid)) begin
          state_d = XFER;
          grant_d = pick_sel;
          gidx_d  = pick_idx;
        end
      end
      XFER: begin
        // Arbitration for the next packet waits for the following IDLE cycle.
        if (accept && mux_last) begin
          state_d     = IDLE;
          grant_d     = '0;
          last_d      = gidx_q;
          pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk156) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      last_q      <= LAST_RST;
      pkt_count_q <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      pkt_count_q <= pkt_count_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tkeep  = tkeep_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign grant             = grant_q;
  assign pkt_count         = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_tx_packet_arbiter
// Purpose  : Self-checking bench for mac_tx_packet_arbiter (4 ports x 64 bit).
//            Cycle table for single-packet and link_ready scenarios, plus
//            source-model sequences for round-robin order, back-pressure,
//            mid-packet reset and packet-counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_tx_packet_arbiter;

  localparam int NP = 4;

  logic        clk156;
  logic        aresetn;
  logic        link_ready;
  logic [3:0]  grant;
  logic [31:0] pkt_count;

  int total = 0;
  int bad   = 0;

  mac_tx_packet_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(64), .KEEP_WIDTH(8)) bus ();

  mac_tx_packet_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
    .clk156     (clk156),
    .aresetn    (aresetn),
    .link_ready (link_ready),
    .bus        (bus),
    .grant      (grant),
    .pkt_count  (pkt_count)
  );

  initial clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        link;
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        mrdy;
    logic [3:0]  e_grant;
    logic [3:0]  e_srdy;
    logic        e_mvld;
    logic [63:0] e_mdata;
    logic [7:0]  e_mkeep;
    logic        e_mlast;
    logic [31:0] e_pkt;
  } vec_t;

  function automatic vec_t v(input logic lk, input logic [3:0] vl, input logic [3:0] ls,
                             input logic [63:0] d, input logic [7:0] k, input logic mr,
                             input logic [3:0] eg, input logic [3:0] es, input logic ev,
                             input logic [63:0] ed, input logic [7:0] ek, input logic el,
                             input logic [31:0] ep);
    vec_t r;
    r.link = lk; r.vld = vl; r.last = ls; r.data = d; r.keep = k; r.mrdy = mr;
    r.e_grant = eg; r.e_srdy = es; r.e_mvld = ev; r.e_mdata = ed;
    r.e_mkeep = ek; r.e_mlast = el; r.e_pkt = ep;
    return r;
  endfunction

  // Source model state: each enabled port streams s_max packets of s_len beats.
  int         s_len  [NP];
  int         s_max  [NP];
  int         s_pkt  [NP];
  int         s_beat [NP];
  logic [3:0] acc;

  logic [63:0] exp_d [16];
  logic [7:0]  exp_k [16];
  logic        exp_l [16];
  int          exp_n;
  int          beat_cyc [16];

  function automatic logic [63:0] bdata(input int p, input int k, input int b);
    return {8'hA5, 8'(p), 8'(k), 8'(b), 32'h1234_5678};
  endfunction

  // Port 3 ends its packets with tkeep=0 to show tkeep passes unchecked.
  function automatic logic [7:0] bkeep(input int p, input bit is_last);
    if (!is_last) return 8'hFF;
    return (p == 3) ? 8'h00 : 8'h0F;
  endfunction

  task automatic src_reset();
    for (int i = 0; i < NP; i++) begin
      s_len[i] = 1; s_max[i] = 0; s_pkt[i] = 0; s_beat[i] = 0;
    end
    acc   = '0;
    exp_n = 0;
  endtask

  task automatic add_exp(input int p, input int k, input int len);
    for (int b = 0; b < len; b++) begin
      exp_d[exp_n] = bdata(p, k, b);
      exp_k[exp_n] = bkeep(p, b == len - 1);
      exp_l[exp_n] = (b == len - 1);
      exp_n++;
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < NP; i++) begin
      bus.s_axis_tvalid[i]        = (s_pkt[i] < s_max[i]);
      bus.s_axis_tlast[i]         = (s_beat[i] == s_len[i] - 1);
      bus.s_axis_tdata[i*64 +: 64] = bdata(i, s_pkt[i], s_beat[i]);
      bus.s_axis_tkeep[i*8 +: 8]   = bkeep(i, s_beat[i] == s_len[i] - 1);
    end
  endtask

  task automatic idle_inputs();
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.m_axis_tready = 1'b1;
  endtask

  task automatic do_reset();
    aresetn    = 1'b0;
    link_ready = 1'b1;
    idle_inputs();
    src_reset();
    repeat (2) @(negedge clk156);
    aresetn = 1'b1;
  endtask

  // Runs the source model until nbeats leave on m_axis or budget expires.
  task automatic run(input int budget, input int nbeats, input bit toggle, input bit tput);
    int          got  = 0;
    int          cyc  = 0;
    bit          seen = 0;
    logic        hold = 1'b0;
    logic [63:0] hold_d = '0;
    while (got < nbeats && cyc < budget) begin
      @(negedge clk156);
      for (int i = 0; i < NP; i++) begin
        if (acc[i]) begin
          if (s_beat[i] == s_len[i] - 1) begin
            s_beat[i] = 0;
            s_pkt[i]++;
          end else begin
            s_beat[i]++;
          end
        end
      end
      drive_src();
      bus.m_axis_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (hold) begin
        check("stall_hold_vld", 64'(bus.m_axis_tvalid), 64'd1);
        check("stall_hold_data", bus.m_axis_tdata, hold_d);
      end
      if (tput && seen && bus.m_axis_tready)
        check("tput_no_bubble", 64'(bus.m_axis_tvalid), 64'd1);
      check("tready_subset_grant", 64'(bus.s_axis_tready & ~grant), 64'd0);
      check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (got < exp_n) begin
          check($sformatf("beat%0d_data", got), bus.m_axis_tdata, exp_d[got]);
          check($sformatf("beat%0d_keep", got), 64'(bus.m_axis_tkeep), 64'(exp_k[got]));
          check($sformatf("beat%0d_last", got), 64'(bus.m_axis_tlast), 64'(exp_l[got]));
        end
        beat_cyc[got] = cyc;
        got++;
        seen = 1;
      end
      hold   = bus.m_axis_tvalid && !bus.m_axis_tready;
      hold_d = bus.m_axis_tdata;
      acc    = bus.s_axis_tvalid & bus.s_axis_tready;
      cyc++;
    end
    if (got < nbeats) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got %0d beats expected %0d", got, nbeats);
    end
  endtask

  // ------------------------------------------------------------------ test
  vec_t vecs [17];

  initial begin
    // Port 0, 3-beat packet, MAC always ready.
    vecs[0]  = v(1'b1, 4'b0001, 4'b0000, 64'hA0, 8'hFF, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'h0,  8'h00, 1'b0, 32'd0);
    vecs[1]  = v(1'b1, 4'b0001, 4'b0000, 64'hA0, 8'hFF, 1'b1, 4'b0001, 4'b0001, 1'b0, 64'h0,  8'h00, 1'b0, 32'd0);
    vecs[2]  = v(1'b1, 4'b0001, 4'b0000, 64'hA1, 8'hFF, 1'b1, 4'b0001, 4'b0001, 1'b1, 64'hA0, 8'hFF, 1'b0, 32'd0);
    vecs[3]  = v(1'b1, 4'b0001, 4'b0001, 64'hA2, 8'h0F, 1'b1, 4'b0001, 4'b0001, 1'b1, 64'hA1, 8'hFF, 1'b0, 32'd0);
    vecs[4]  = v(1'b1, 4'b0000, 4'b0000, 64'h0,  8'h00, 1'b1, 4'b0000, 4'b0000, 1'b1, 64'hA2, 8'h0F, 1'b1, 32'd1);
    vecs[5]  = v(1'b1, 4'b0000, 4'b0000, 64'h0,  8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'h0,  8'h00, 1'b0, 32'd1);
    // Ports 1 and 3 waiting on link_ready; port data is row data + port index.
    vecs[6]  = v(1'b0, 4'b1010, 4'b0000, 64'hB0, 8'hFF, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'h0,  8'h00, 1'b0, 32'd1);
    vecs[7]  = v(1'b0, 4'b1010, 4'b0000, 64'hB0, 8'hFF, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'h0,  8'h00, 1'b0, 32'd1);
    vecs[8]  = v(1'b1, 4'b1010, 4'b0000, 64'hB0, 8'hFF, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'h0,  8'h00, 1'b0, 32'd1);
    vecs[9]  = v(1'b0, 4'b1010, 4'b0000, 64'hB0, 8'hFF, 1'b1, 4'b0010, 4'b0010, 1'b0, 64'h0,  8'h00, 1'b0, 32'd1);
    vecs[10] = v(1'b0, 4'b1010, 4'b0010, 64'hC0, 8'h0F, 1'b1, 4'b0010, 4'b0010, 1'b1, 64'hB1, 8'hFF, 1'b0, 32'd1);
    vecs[11] = v(1'b0, 4'b1000, 4'b0000, 64'hC0, 8'hFF, 1'b1, 4'b0000, 4'b0000, 1'b1, 64'hC1, 8'h0F, 1'b1, 32'd2);
    vecs[12] = v(1'b0, 4'b1000, 4'b0000, 64'hC0, 8'hFF, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'h0,  8'h00, 1'b0, 32'd2);
    vecs[13] = v(1'b0, 4'b1000, 4'b0000, 64'hC0, 8'hFF, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'h0,  8'h00, 1'b0, 32'd2);
    vecs[14] = v(1'b1, 4'b1000, 4'b0000, 64'hD0, 8'hFF, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'h0,  8'h00, 1'b0, 32'd2);
    vecs[15] = v(1'b1, 4'b1000, 4'b1000, 64'hD0, 8'hFF, 1'b1, 4'b1000, 4'b1000, 1'b0, 64'h0,  8'h00, 1'b0, 32'd2);
    vecs[16] = v(1'b1, 4'b0000, 4'b0000, 64'h0,  8'h00, 1'b1, 4'b0000, 4'b0000, 1'b1, 64'hD3, 8'hFF, 1'b1, 32'd3);

    // ---- reset values
    aresetn    = 1'b0;
    link_ready = 1'b1;
    idle_inputs();
    src_reset();
    repeat (3) @(negedge clk156);
    #1;
    check("rst_grant",  64'(grant), 64'd0);
    check("rst_mvld",   64'(bus.m_axis_tvalid), 64'd0);
    check("rst_mlast",  64'(bus.m_axis_tlast), 64'd0);
    check("rst_mdata",  bus.m_axis_tdata, 64'd0);
    check("rst_mkeep",  64'(bus.m_axis_tkeep), 64'd0);
    check("rst_srdy",   64'(bus.s_axis_tready), 64'd0);
    check("rst_pkt",    64'(pkt_count), 64'd0);
    aresetn = 1'b1;

    // ---- cycle table
    for (int r = 0; r < 17; r++) begin
      @(negedge clk156);
      link_ready        = vecs[r].link;
      bus.m_axis_tready = vecs[r].mrdy;
      bus.s_axis_tvalid = vecs[r].vld;
      bus.s_axis_tlast  = vecs[r].last;
      for (int i = 0; i < NP; i++) begin
        bus.s_axis_tdata[i*64 +: 64] = vecs[r].data + 64'(i);
        bus.s_axis_tkeep[i*8 +: 8]   = vecs[r].keep;
      end
      #1;
      check($sformatf("row%0d_grant", r), 64'(grant), 64'(vecs[r].e_grant));
      check($sformatf("row%0d_srdy", r),  64'(bus.s_axis_tready), 64'(vecs[r].e_srdy));
      check($sformatf("row%0d_mvld", r),  64'(bus.m_axis_tvalid), 64'(vecs[r].e_mvld));
      check($sformatf("row%0d_mdata", r), bus.m_axis_tdata, vecs[r].e_mdata);
      check($sformatf("row%0d_mkeep", r), 64'(bus.m_axis_tkeep), 64'(vecs[r].e_mkeep));
      check($sformatf("row%0d_mlast", r), 64'(bus.m_axis_tlast), 64'(vecs[r].e_mlast));
      check($sformatf("row%0d_pkt", r),   64'(pkt_count), 64'(vecs[r].e_pkt));
    end

    // ---- all ports busy with 2-beat packets: order 0,1,2,3,0, one idle gap
    @(negedge clk156);
    do_reset();
    for (int i = 0; i < NP; i++) begin
      s_len[i] = 2;
      s_max[i] = 100;
    end
    add_exp(0, 0, 2); add_exp(1, 0, 2); add_exp(2, 0, 2); add_exp(3, 0, 2); add_exp(0, 1, 2);
    run(100, 10, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      check($sformatf("rr_pkt%0d_back_to_back", k), 64'(beat_cyc[2*k+1] - beat_cyc[2*k]), 64'd1);
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_gap%0d_one_idle", k), 64'(beat_cyc[2*k+2] - beat_cyc[2*k+1]), 64'd2);

    // ---- port 2, 6 beats, MAC ready toggling
    @(negedge clk156);
    do_reset();
    s_len[2] = 6;
    s_max[2] = 1;
    add_exp(2, 0, 6);
    run(100, 6, 1'b1, 1'b1);
    check("stall_pkt_count", 64'(pkt_count), 64'd1);

    // ---- reset during beat 2 of a 5-beat packet
    src_reset();
    s_len[0] = 5;
    s_max[0] = 1;
    add_exp(0, 0, 5);
    run(50, 2, 1'b0, 1'b0);
    aresetn = 1'b0;
    bus.s_axis_tvalid = '0;
    @(negedge clk156);
    #1;
    check("midrst_mvld",  64'(bus.m_axis_tvalid), 64'd0);
    check("midrst_grant", 64'(grant), 64'd0);
    check("midrst_pkt",   64'(pkt_count), 64'd0);
    check("midrst_srdy",  64'(bus.s_axis_tready), 64'd0);
    aresetn = 1'b1;
    // Before reset port 3 would have been next; afterwards port 0 must win.
    src_reset();
    s_max[0] = 1;
    s_max[3] = 1;
    add_exp(0, 0, 1);
    add_exp(3, 0, 1);
    run(40, 2, 1'b0, 1'b0);
    check("prio_pkt_count", 64'(pkt_count), 64'd2);

    // ---- pkt_count wrap
    @(negedge clk156);
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    @(negedge clk156);
    release dut.pkt_count_q;
    #1;
    check("wrap_preload", 64'(pkt_count), 64'hFFFF_FFFF);
    src_reset();
    s_max[1] = 1;
    add_exp(1, 0, 1);
    run(40, 1, 1'b0, 1'b0);
    check("wrap_to_zero", 64'(pkt_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
